uart_tx_arbiter: RTL

- Round-robin arbiter sharing a single UART_tx instance between NREQ byte producers, e.g. the uart_top data register path, a status reporter and a debug dumper.
- Each requester offers bytes on a valid/ready handshake. The arbiter latches the winning byte, drives TxEn/TxData into UART_tx, and holds them until TxDone.
- Optional packet lock keeps the grant on one requester until it marks its last byte.
- Sits between the requesters and UART_tx, in the same clock domain as UART_BaudRate_generator.

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_tx among NREQ byte producers.
// Optional packet lock holds the grant until the owner marks its last byte.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned GNT_W        = 2,
    parameter int unsigned IFG_CYCLES   = 0,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                TxEn,
    output logic [7:0]          TxData,
    input  logic                TxDone,
    output logic [GNT_W-1:0]    grant_o,
    output logic                busy_o,
    output logic                locked_o,
    output logic                lock_drop_o,
    output logic [CNT_W-1:0]    byte_cnt_o
);

    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    logic [GNT_W-1:0]   ptr;
    logic               lock;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               owner_valid;
    logic               timeout_hit;
    logic               lock_eff;
    logic [NREQ-1:0]    cand;
    logic               win_found;
    logic [GNT_W-1:0]   win_idx;
    int unsigned        scan_idx;
    logic [7:0]         req_byte [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_byte[g] = req_data[g*8 +: 8];
    end

    // Timeout fires only when the owner stays silent; an owner valid in the
    // expiry cycle wins instead, so the lock survives.
    assign owner_valid = req_valid[grant_o];
    assign timeout_hit = (state == IDLE) && lock && !owner_valid &&
                         (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
    assign lock_eff    = lock && !timeout_hit;
    assign cand        = lock_eff ? (req_valid & (NREQ'(1) << grant_o)) : req_valid;
    assign locked_o    = lock;

    // First candidate at or after ptr+1, modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = 32'(ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!win_found && cand[GNT_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = GNT_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (Rst_n && (state == IDLE) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= IDLE;
            ptr         <= GNT_W'(NREQ - 1);
            lock        <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            TxEn        <= 1'b0;
            TxData      <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
            lock_drop_o <= 1'b0;
            byte_cnt_o  <= '0;
        end else begin
            lock_drop_o <= timeout_hit;
            case (state)
                IDLE: begin
                    if (timeout_hit) begin
                        lock    <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (lock && !owner_valid) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end else begin
                        tmo_cnt <= '0;
                    end
                    if (win_found) begin
                        TxData  <= req_byte[win_idx];
                        grant_o <= win_idx;
                        ptr     <= win_idx;
                        TxEn    <= 1'b1;
                        busy_o  <= 1'b1;
                        lock    <= ~req_last[win_idx];
                        tmo_cnt <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (TxDone) begin
                        TxEn       <= 1'b0;
                        byte_cnt_o <= byte_cnt_o + 1'b1;
                        if (IFG_CYCLES == 0) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(IFG_CYCLES - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
